// File: rtl/response_router_pkg.sv
// Shared widths and the response record for the response return path; defaults for ID_WIDTH,
// DATA_WIDTH, ADDRESS_WIDTH and RESP_FIFO_DEPTH apply only when not already defined by the build.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 8
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef RESP_FIFO_DEPTH
`define RESP_FIFO_DEPTH 4
`endif

package response_router_pkg;

  localparam int ID_W   = `ID_WIDTH;
  localparam int DATA_W = `DATA_WIDTH;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } resp_t;

  localparam int RESP_W = $bits(resp_t);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Generic FIFO with registered storage and combinational head read.
// Latency: push visible at head one cycle later. Backpressure: push while full dropped unless popped same cycle.
// Full/empty come from pointers one bit wider than the index.
module resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok   = pop & ~empty;
  // A pop frees the head slot this edge, so a push into a full FIFO may still land.
  assign push_ok  = push & (~full | pop_ok);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/response_router.sv
// Steers shared-resource responses to two buffered consumer ports and tracks outstanding credits per port.
// Latency: 1 cycle in to out. Backpressure: consumer stall holds head; out_stall_k at DEPTH outstanding.
// Optional RESP_DROP_COUNT_EN adds a saturating count of responses dropped on a full FIFO.
module response_router
  import response_router_pkg::*;
#(
  parameter int DEPTH     = `RESP_FIFO_DEPTH,
  parameter int ROUTE_BIT = `ID_WIDTH - 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_issue_valid,
  input  logic                   in_issue_choice,
  output logic                   out_stall_1,
  output logic                   out_stall_2,
  input  logic [`DATA_WIDTH-1:0] in_data,
  input  logic [`ID_WIDTH-1:0]   in_id,
  input  logic                   in_valid,
  output logic [`DATA_WIDTH-1:0] out_data_1,
  output logic [`ID_WIDTH-1:0]   out_id_1,
  output logic                   out_valid_1,
  output logic [`DATA_WIDTH-1:0] out_data_2,
  output logic [`ID_WIDTH-1:0]   out_id_2,
  output logic                   out_valid_2,
  input  logic                   in_stall_1,
  input  logic                   in_stall_2
`ifdef RESP_DROP_COUNT_EN
  ,
  output logic [7:0]             out_drop_count
`endif
);

  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEPTH);

  // Index 0 is consumer port 1, index 1 is consumer port 2.
  logic [1:0]         issue;
  logic [1:0]         push;
  logic [1:0]         pop;
  logic [1:0]         full;
  logic [1:0]         empty;
  logic [1:0][CW-1:0] cnt;
  logic [1:0][CW-1:0] cnt_nxt;
  logic [1:0]         stall_q;
  resp_t              in_resp;
  resp_t              head_1;
  resp_t              head_2;

  assign in_resp  = '{id: in_id, data: in_data};
  assign issue[0] = in_issue_valid &  in_issue_choice;
  assign issue[1] = in_issue_valid & ~in_issue_choice;
  assign push[0]  = in_valid &  in_id[ROUTE_BIT];
  assign push[1]  = in_valid & ~in_id[ROUTE_BIT];
  assign pop[0]   = ~empty[0] & ~in_stall_1;
  assign pop[1]   = ~empty[1] & ~in_stall_2;

  resp_fifo #(.DEPTH(DEPTH), .WIDTH(RESP_W)) u_fifo_1 (
    .clk      (clk),
    .reset    (reset),
    .push     (push[0]),
    .push_dat (in_resp),
    .pop      (pop[0]),
    .head_dat (head_1),
    .full     (full[0]),
    .empty    (empty[0])
  );

  resp_fifo #(.DEPTH(DEPTH), .WIDTH(RESP_W)) u_fifo_2 (
    .clk      (clk),
    .reset    (reset),
    .push     (push[1]),
    .push_dat (in_resp),
    .pop      (pop[1]),
    .head_dat (head_2),
    .full     (full[1]),
    .empty    (empty[1])
  );

  assign out_valid_1 = ~empty[0];
  assign out_data_1  = head_1.data;
  assign out_id_1    = head_1.id;
  assign out_valid_2 = ~empty[1];
  assign out_data_2  = head_2.data;
  assign out_id_2    = head_2.id;

  // Saturate at both ends so arbiter protocol violations cannot wrap the credit count.
  always_comb begin
    cnt_nxt = cnt;
    for (int k = 0; k < 2; k++) begin
      if (issue[k] && !pop[k] && cnt[k] != CNT_MAX)
        cnt_nxt[k] = cnt[k] + CW'(1);
      else if (pop[k] && !issue[k] && cnt[k] != '0)
        cnt_nxt[k] = cnt[k] - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      stall_q <= '0;
    end else begin
      cnt <= cnt_nxt;
      for (int k = 0; k < 2; k++) stall_q[k] <= (cnt_nxt[k] == CNT_MAX);
    end
  end

  assign out_stall_1 = stall_q[0];
  assign out_stall_2 = stall_q[1];

`ifdef RESP_DROP_COUNT_EN
  logic       drop;
  logic [7:0] drop_cnt;

  assign drop           = |(push & full & ~pop);
  assign out_drop_count = drop_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    drop_cnt <= '0;
    else if (drop) drop_cnt <= sat_inc8(drop_cnt);
  end
`endif

endmodule
